dram_reader: RTL and testbench



---
 rtl/dram_reader_pkg.sv | 16 +
 rtl/dram_reader_ar_gen.sv | 78 +++++++
 rtl/dram_reader.sv | 144 ++++++++++++++
 tb/tb_dram_reader.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_reader_pkg.sv
// Shared constants and state type for the DRAM read master.
// Fixed-size AXI3 burst geometry: 16 beats of 8 bytes, INCR.
package dram_reader_pkg;
    localparam int unsigned BURST_BYTES    = 128;
    localparam int unsigned BURST_BEATS    = 16;

    localparam logic [3:0] AXI_LEN_16      = 4'b1111;
    localparam logic [1:0] AXI_SIZE_8B     = 2'b11;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/dram_reader_ar_gen.sv
// AR-channel generator: walks burst addresses and bounds bursts in flight.
// outstanding counts accepted AR bursts whose RLAST beat has not yet been taken.
module dram_reader_ar_gen
    import dram_reader_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        job_load,
    input  logic        job_start,
    input  logic [24:0] start_burst,
    input  logic [24:0] nbursts,
    input  logic        burst_done,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic        arvalid,
    output state_e      a_state
);
    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    state_e      a_state_q, a_state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [24:0] a_count_q, a_count_d;
    logic [3:0]  outstanding_q, outstanding_d;
    logic        ar_fire;

    assign ar_fire = arvalid && arready;
    assign araddr  = araddr_q;
    assign a_state = a_state_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            a_state_q <= IDLE;
        end else begin
            a_state_q <= a_state_d;
        end
    end

    always_comb begin
        a_state_d = a_state_q;
        case (a_state_q)
            IDLE:    if (job_start) a_state_d = RUN;
            RUN:     if (ar_fire && (a_count_q == 25'd1)) a_state_d = IDLE;
            default: a_state_d = IDLE;
        endcase
    end

    // The gate only sees AR handshakes raise the count, so a pending request is never withdrawn.
    always_comb begin
        arvalid = (a_state_q == RUN) && (outstanding_q < MAX_OUT);
    end

    always_comb begin
        araddr_d  = araddr_q;
        a_count_d = a_count_q;
        if (job_load) begin
            araddr_d  = {start_burst, 7'b0};
            a_count_d = nbursts;
        end else if (ar_fire) begin
            araddr_d  = araddr_q + 32'(BURST_BYTES);
            a_count_d = a_count_q - 25'd1;
        end
        outstanding_d = outstanding_q + {3'b0, ar_fire} - {3'b0, burst_done};
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            araddr_q      <= '0;
            a_count_q     <= '0;
            outstanding_q <= '0;
        end else begin
            araddr_q      <= araddr_d;
            a_count_q     <= a_count_d;
            outstanding_q <= outstanding_d;
        end
    end
endmodule

// File: rtl/dram_reader.sv
// dram_reader: AXI3 read master streaming a contiguous DRAM region as 64-bit words.
// Define DRAM_READER_RESP_CHECK_EN to build the sticky RRESP/RLAST error check.
module dram_reader
    import dram_reader_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    output logic [3:0]  M_AXI_ARLEN,
    output logic [1:0]  M_AXI_ARSIZE,
    output logic [1:0]  M_AXI_ARBURST,
    input  logic [63:0] M_AXI_RDATA,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY,
    input  logic        M_AXI_RLAST,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        CONFIG_VALID,
    output logic        CONFIG_READY,
    input  logic [31:0] CONFIG_START_ADDR,
    input  logic [31:0] CONFIG_NBYTES,
    output logic [63:0] DATA,
    output logic        DATA_VALID,
    input  logic        DATA_READY,
    output logic        ERROR
);
    state_e      a_state;
    state_e      r_state_q, r_state_d;
    logic [28:0] r_beats_q, r_beats_d;
    logic [3:0]  beat_idx_q, beat_idx_d;
    logic [24:0] nbursts;
    logic        accept, job_start, beat, burst_done;
    logic        unused_bits;

    assign nbursts      = CONFIG_NBYTES[31:7];
    assign CONFIG_READY = (a_state == IDLE) && (r_state_q == IDLE);
    assign accept       = CONFIG_VALID && CONFIG_READY;
    assign job_start    = accept && (nbursts != 25'd0);
    assign beat         = M_AXI_RVALID && M_AXI_RREADY;
    assign burst_done   = beat && M_AXI_RLAST;

    assign M_AXI_ARLEN   = AXI_LEN_16;
    assign M_AXI_ARSIZE  = AXI_SIZE_8B;
    assign M_AXI_ARBURST = AXI_BURST_INCR;

    dram_reader_ar_gen #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_ar_gen (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .job_load    (accept),
        .job_start   (job_start),
        .start_burst (CONFIG_START_ADDR[31:7]),
        .nbursts     (nbursts),
        .burst_done  (burst_done),
        .arready     (M_AXI_ARREADY),
        .araddr      (M_AXI_ARADDR),
        .arvalid     (M_AXI_ARVALID),
        .a_state     (a_state)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state_q <= IDLE;
        end else begin
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            IDLE:    if (job_start) r_state_d = RUN;
            RUN:     if (beat && (r_beats_q == 29'd1)) r_state_d = IDLE;
            default: r_state_d = IDLE;
        endcase
    end

    // R channel passes straight through to the stream: no buffering, zero latency.
    always_comb begin
        M_AXI_RREADY = 1'b0;
        DATA_VALID   = 1'b0;
        if (r_state_q == RUN) begin
            M_AXI_RREADY = DATA_READY;
            DATA_VALID   = M_AXI_RVALID;
        end
    end

    assign DATA = M_AXI_RDATA;

    always_comb begin
        r_beats_d  = r_beats_q;
        beat_idx_d = beat_idx_q;
        if (accept) begin
            r_beats_d  = {nbursts, 4'b0};
            beat_idx_d = 4'd0;
        end else if (beat) begin
            r_beats_d  = r_beats_q - 29'd1;
            beat_idx_d = beat_idx_q + 4'd1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_beats_q  <= '0;
            beat_idx_q <= '0;
        end else begin
            r_beats_q  <= r_beats_d;
            beat_idx_q <= beat_idx_d;
        end
    end

`ifdef DRAM_READER_RESP_CHECK_EN
    logic error_q, error_d;

    // beat_idx wraps every 16 beats, so RLAST must coincide exactly with index 15.
    always_comb begin
        error_d = error_q;
        if (accept) begin
            error_d = 1'b0;
        end else if (beat && ((M_AXI_RRESP != AXI_RESP_OKAY) ||
                              (M_AXI_RLAST != (beat_idx_q == 4'd15)))) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign ERROR       = error_q;
    assign unused_bits = ^{CONFIG_START_ADDR[6:0], CONFIG_NBYTES[6:0]};
`else
    assign ERROR       = 1'b0;
    assign unused_bits = ^{CONFIG_START_ADDR[6:0], CONFIG_NBYTES[6:0], M_AXI_RRESP, beat_idx_q};
`endif
endmodule

// File: tb/tb_dram_reader.sv
// Directed bench for dram_reader: AXI slave responder, expected-data queue, immediate assertions.
// Built with MAX_OUTSTANDING=2; error expectations follow DRAM_READER_RESP_CHECK_EN.
module tb_dram_reader;
    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [3:0]  M_AXI_ARLEN;
    logic [1:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic [63:0] M_AXI_RDATA;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;
    logic        M_AXI_RLAST;
    logic [1:0]  M_AXI_RRESP;
    logic        CONFIG_VALID;
    logic        CONFIG_READY;
    logic [31:0] CONFIG_START_ADDR;
    logic [31:0] CONFIG_NBYTES;
    logic [63:0] DATA;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic        ERROR;

    dram_reader #(.MAX_OUTSTANDING(2)) dut (
        .ACLK              (ACLK),
        .ARESETN           (ARESETN),
        .M_AXI_ARADDR      (M_AXI_ARADDR),
        .M_AXI_ARVALID     (M_AXI_ARVALID),
        .M_AXI_ARREADY     (M_AXI_ARREADY),
        .M_AXI_ARLEN       (M_AXI_ARLEN),
        .M_AXI_ARSIZE      (M_AXI_ARSIZE),
        .M_AXI_ARBURST     (M_AXI_ARBURST),
        .M_AXI_RDATA       (M_AXI_RDATA),
        .M_AXI_RVALID      (M_AXI_RVALID),
        .M_AXI_RREADY      (M_AXI_RREADY),
        .M_AXI_RLAST       (M_AXI_RLAST),
        .M_AXI_RRESP       (M_AXI_RRESP),
        .CONFIG_VALID      (CONFIG_VALID),
        .CONFIG_READY      (CONFIG_READY),
        .CONFIG_START_ADDR (CONFIG_START_ADDR),
        .CONFIG_NBYTES     (CONFIG_NBYTES),
        .DATA              (DATA),
        .DATA_VALID        (DATA_VALID),
        .DATA_READY        (DATA_READY),
        .ERROR             (ERROR)
    );

    always #5 ACLK = ~ACLK;

`ifdef DRAM_READER_RESP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_ar_q[$];
    logic [31:0] burst_q[$];
    logic [31:0] ar_log[$];
    int          cur_beat = 0;
    int          job_beats = 0;
    int          ar_cnt = 0;
    int          bursts_done = 0;
    int          max_out = 0;
    int          rresp_err_at = -1;
    int          early_last_at = -1;
    bit          rvalid_en = 1'b0;
    bit          bp_mode = 1'b0;
    bit          ar_toggle = 1'b0;
    bit          ar_pend = 1'b0;
    logic [31:0] ar_pend_addr = '0;

    function automatic logic [63:0] mk_data(input logic [31:0] a, input int b);
        logic [31:0] x;
        x = a + 32'(b) * 32'd8;
        return {x ^ 32'hDEAD_BEEF, x};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Slave side: serve accepted bursts in order, 16 beats each.
    task automatic drive_inputs();
        M_AXI_RVALID = rvalid_en && (burst_q.size() > 0);
        if (M_AXI_RVALID) begin
            M_AXI_RDATA = mk_data(burst_q[0], cur_beat);
            M_AXI_RLAST = (cur_beat == 15) || (job_beats == early_last_at);
            M_AXI_RRESP = (job_beats == rresp_err_at) ? 2'b10 : 2'b00;
        end else begin
            M_AXI_RDATA = '0;
            M_AXI_RLAST = 1'b0;
            M_AXI_RRESP = 2'b00;
        end
        DATA_READY    = bp_mode ? ~DATA_READY : 1'b1;
        M_AXI_ARREADY = ar_toggle ? ~M_AXI_ARREADY : 1'b1;
    endtask

    task automatic observe();
        int outst;
        if (ar_pend) begin
            check1("ar_hold_valid", M_AXI_ARVALID, 1'b1);
            check("ar_hold_addr", 64'(M_AXI_ARADDR), 64'(ar_pend_addr));
        end
        ar_pend      = M_AXI_ARVALID && !M_AXI_ARREADY;
        ar_pend_addr = M_AXI_ARADDR;
        if (bp_mode && (exp_q.size() > 0)) begin
            check1("rready_mirror", M_AXI_RREADY, DATA_READY);
            check1("dvalid_mirror", DATA_VALID, M_AXI_RVALID);
        end
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            ar_cnt++;
            ar_log.push_back(M_AXI_ARADDR);
            burst_q.push_back(M_AXI_ARADDR);
            if (exp_ar_q.size() == 0) check("ar_extra", 64'(exp_ar_q.size()), 64'd1);
            else check("araddr", 64'(M_AXI_ARADDR), 64'(exp_ar_q.pop_front()));
            outst = ar_cnt - bursts_done;
            if (outst > max_out) max_out = outst;
        end
        if (M_AXI_RVALID && M_AXI_RREADY) begin
            check1("dvalid_on_beat", DATA_VALID, 1'b1);
            if (exp_q.size() == 0) check("beat_extra", 64'(exp_q.size()), 64'd1);
            else check("data", DATA, exp_q.pop_front());
            job_beats++;
            if (cur_beat == 15) begin
                cur_beat = 0;
                void'(burst_q.pop_front());
                bursts_done++;
            end else begin
                cur_beat++;
            end
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
        drive_inputs();
        @(negedge ACLK);
        observe();
    endtask

    task automatic start_job(input logic [31:0] start, input logic [31:0] nbytes);
        logic [31:0] base;
        logic [31:0] a;
        int          n;
        cur_beat    = 0;
        job_beats   = 0;
        ar_cnt      = 0;
        bursts_done = 0;
        max_out     = 0;
        ar_log.delete();
        base = {start[31:7], 7'b0};
        n    = int'(nbytes[31:7]);
        for (int i = 0; i < n; i++) begin
            a = base + 32'(i) * 32'd128;
            exp_ar_q.push_back(a);
            for (int b = 0; b < 16; b++) exp_q.push_back(mk_data(a, b));
        end
        check1("cfg_ready_idle", CONFIG_READY, 1'b1);
        check1("arvalid_idle", M_AXI_ARVALID, 1'b0);
        CONFIG_START_ADDR = start;
        CONFIG_NBYTES     = nbytes;
        CONFIG_VALID      = 1'b1;
        step();
        CONFIG_VALID = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        int n;
        n = 0;
        while (((exp_q.size() > 0) || (exp_ar_q.size() > 0)) && (n < budget)) begin
            step();
            n++;
        end
        check("job_timeout", 64'(exp_q.size() + exp_ar_q.size()), 64'd0);
        check1("busy_at_last_beat", CONFIG_READY, 1'b0);
        step();
        check1("ready_after_last", CONFIG_READY, 1'b1);
    endtask

    task automatic do_reset();
        ARESETN   = 1'b0;
        rvalid_en = 1'b0;
        ar_pend   = 1'b0;
        exp_q.delete();
        exp_ar_q.delete();
        burst_q.delete();
        cur_beat = 0;
        step();
        check1("rst_arvalid", M_AXI_ARVALID, 1'b0);
        check1("rst_rready", M_AXI_RREADY, 1'b0);
        check1("rst_cfg_ready", CONFIG_READY, 1'b1);
        ARESETN   = 1'b1;
        rvalid_en = 1'b1;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ARESETN           = 1'b0;
        M_AXI_ARREADY     = 1'b1;
        M_AXI_RDATA       = '0;
        M_AXI_RVALID      = 1'b0;
        M_AXI_RLAST       = 1'b0;
        M_AXI_RRESP       = 2'b00;
        CONFIG_VALID      = 1'b0;
        CONFIG_START_ADDR = '0;
        CONFIG_NBYTES     = '0;
        DATA_READY        = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);

        // Reset state, with RVALID forced high to prove the IDLE gating.
        M_AXI_RVALID = 1'b1;
        #1;
        check1("reset_arvalid", M_AXI_ARVALID, 1'b0);
        check("reset_araddr", 64'(M_AXI_ARADDR), 64'd0);
        check1("reset_rready", M_AXI_RREADY, 1'b0);
        check1("reset_dvalid", DATA_VALID, 1'b0);
        check1("reset_error", ERROR, 1'b0);
        check1("reset_cfg_ready", CONFIG_READY, 1'b1);
        check("arlen", 64'(M_AXI_ARLEN), 64'h0f);
        check("arsize", 64'(M_AXI_ARSIZE), 64'h3);
        check("arburst", 64'(M_AXI_ARBURST), 64'h1);
        M_AXI_RVALID = 1'b0;
        ARESETN      = 1'b1;
        rvalid_en    = 1'b1;
        step();
        check1("cfg_ready_after_reset", CONFIG_READY, 1'b1);

        // Basic two-burst job.
        start_job(32'h0000_1000, 32'd256);
        check1("first_arvalid", M_AXI_ARVALID, 1'b1);
        check("first_araddr", 64'(M_AXI_ARADDR), 64'h1000);
        run_to_done(500);
        check("basic_ar_cnt", 64'(ar_cnt), 64'd2);
        check("basic_beats", 64'(job_beats), 64'd32);
        if (ar_log.size() == 2) begin
            check("basic_ar0", 64'(ar_log[0]), 64'h1000);
            check("basic_ar1", 64'(ar_log[1]), 64'h1080);
        end

        // Throttle: at most two bursts in flight.
        rvalid_en = 1'b0;
        start_job(32'h0000_2000, 32'd1024);
        repeat (50) step();
        check("throttle_ar_held", 64'(ar_cnt), 64'd2);
        check1("throttle_arvalid_low", M_AXI_ARVALID, 1'b0);
        rvalid_en = 1'b1;
        run_to_done(2000);
        check("throttle_ar_total", 64'(ar_cnt), 64'd8);
        check("throttle_max_out", 64'(max_out), 64'd2);
        check("throttle_beats", 64'(job_beats), 64'd128);

        // Backpressure on the stream, stalls on AR.
        bp_mode   = 1'b1;
        ar_toggle = 1'b1;
        start_job(32'h0000_8000, 32'd384);
        run_to_done(2000);
        bp_mode   = 1'b0;
        ar_toggle = 1'b0;
        check("bp_beats", 64'(job_beats), 64'd48);
        check("bp_ar_cnt", 64'(ar_cnt), 64'd3);

        // Sub-burst byte count: no traffic at all.
        start_job(32'h0000_1000, 32'd100);
        for (int i = 0; i < 4; i++) begin
            check1("nb100_arvalid", M_AXI_ARVALID, 1'b0);
            check1("nb100_cfg_ready", CONFIG_READY, 1'b1);
            step();
        end
        check("nb100_ar_cnt", 64'(ar_cnt), 64'd0);

        // Unaligned start is truncated to the burst boundary.
        start_job(32'h1234_567F, 32'd128);
        check("unaligned_araddr", 64'(M_AXI_ARADDR), 64'h1234_5600);
        run_to_done(500);

        // Address wraps past the top of the 32-bit space.
        start_job(32'hFFFF_FF80, 32'd256);
        run_to_done(500);
        check("wrap_ar_cnt", 64'(ar_cnt), 64'd2);
        if (ar_log.size() == 2) begin
            check("wrap_ar0", 64'(ar_log[0]), 64'hFFFF_FF80);
            check("wrap_ar1", 64'(ar_log[1]), 64'h0000_0000);
        end

        // Error response on beat 5: sticky to job end, cleared by next accept.
        rresp_err_at = 5;
        start_job(32'h0000_4000, 32'd256);
        check1("err_clear_at_start", ERROR, 1'b0);
        run_to_done(500);
        check1("rresp_err_sticky", ERROR, EXP_ERR);
        rresp_err_at = -1;
        start_job(32'h0000_5000, 32'd128);
        check1("err_cleared_on_accept", ERROR, 1'b0);
        run_to_done(500);
        check1("err_clean_job", ERROR, 1'b0);

        // Early RLAST on beat 14; outstanding is corrupted afterwards, so reset.
        early_last_at = 14;
        start_job(32'h0000_6000, 32'd128);
        run_to_done(500);
        check1("early_rlast_err", ERROR, EXP_ERR);
        early_last_at = -1;
        do_reset();
        check1("err_after_reset", ERROR, 1'b0);

        // Reset in the middle of a burst, then a clean job.
        start_job(32'h0000_3000, 32'd512);
        for (int i = 0; i < 200 && job_beats < 7; i++) step();
        check("reach_beat7", 64'(job_beats), 64'd7);
        do_reset();
        start_job(32'h0000_7000, 32'd256);
        run_to_done(500);
        check("post_reset_beats", 64'(job_beats), 64'd32);
        check("post_reset_ar_cnt", 64'(ar_cnt), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
